// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory and decode-side signal bundle for fetch_ctrl
// Optional misalign_out port exists only when FETCH_CTRL_MISALIGN_CHECK_EN is defined.
interface fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fetch_ctrl_mem_req_out;
    logic [DATA_WIDTH-1:0] fetch_ctrl_mem_addr_out;
    logic                  fetch_ctrl_mem_gnt_in;
    logic                  fetch_ctrl_mem_rvalid_in;
    logic [DATA_WIDTH-1:0] fetch_ctrl_mem_rdata_in;
    logic                  fetch_ctrl_stall_in;
    logic                  fetch_ctrl_redirect_in;
    logic [DATA_WIDTH-1:0] fetch_ctrl_redirect_addr_in;
    logic                  fetch_ctrl_instr_valid_out;
    logic [DATA_WIDTH-1:0] fetch_ctrl_instr_out;
    logic [DATA_WIDTH-1:0] fetch_ctrl_instr_pc_out;
`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
    logic                  fetch_ctrl_misalign_out;
`endif

    modport master (
`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
        output fetch_ctrl_misalign_out,
`endif
        output fetch_ctrl_mem_req_out,
        output fetch_ctrl_mem_addr_out,
        input  fetch_ctrl_mem_gnt_in,
        input  fetch_ctrl_mem_rvalid_in,
        input  fetch_ctrl_mem_rdata_in,
        input  fetch_ctrl_stall_in,
        input  fetch_ctrl_redirect_in,
        input  fetch_ctrl_redirect_addr_in,
        output fetch_ctrl_instr_valid_out,
        output fetch_ctrl_instr_out,
        output fetch_ctrl_instr_pc_out
    );

    modport slave (
`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
        input  fetch_ctrl_misalign_out,
`endif
        input  fetch_ctrl_mem_req_out,
        input  fetch_ctrl_mem_addr_out,
        output fetch_ctrl_mem_gnt_in,
        output fetch_ctrl_mem_rvalid_in,
        output fetch_ctrl_mem_rdata_in,
        output fetch_ctrl_stall_in,
        output fetch_ctrl_redirect_in,
        output fetch_ctrl_redirect_addr_in,
        input  fetch_ctrl_instr_valid_out,
        input  fetch_ctrl_instr_out,
        input  fetch_ctrl_instr_pc_out
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD) with redirect and kill
// Define FETCH_CTRL_MISALIGN_CHECK_EN to reject redirects whose target is not word aligned.
module fetch_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic          clock_in,
    input logic          reset_in,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic                  kill;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] mem_addr;
    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] instr_pc;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] pc_sel;
    logic [DATA_WIDTH-1:0] pc_inc;

`ifdef FETCH_CTRL_MISALIGN_CHECK_EN
    logic misaligned;
    logic misalign;

    assign misaligned = bus.fetch_ctrl_redirect_in && (bus.fetch_ctrl_redirect_addr_in[1:0] != 2'b00);
    assign redirect   = bus.fetch_ctrl_redirect_in && !misaligned;
    assign bus.fetch_ctrl_misalign_out = misalign;

    // one-cycle pulse flagging a rejected unaligned redirect
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) misalign <= 1'b0;
        else          misalign <= misaligned;
    end
`else
    assign redirect = bus.fetch_ctrl_redirect_in;
`endif

    assign pc_sel = redirect ? bus.fetch_ctrl_redirect_addr_in : pc;
    assign pc_inc = pc + DATA_WIDTH'(4);

    assign bus.fetch_ctrl_mem_req_out     = mem_req;
    assign bus.fetch_ctrl_mem_addr_out    = mem_addr;
    assign bus.fetch_ctrl_instr_valid_out = instr_valid;
    assign bus.fetch_ctrl_instr_out       = instr;
    assign bus.fetch_ctrl_instr_pc_out    = instr_pc;

    // fetch FSM; every output is registered alongside the state transition that implies it
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state       <= IDLE;
            pc          <= RESET_VECTOR;
            kill        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_VECTOR;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    mem_req  <= 1'b1;
                    pc       <= pc_sel;
                    mem_addr <= pc_sel;
                end
                REQ: begin
                    pc <= pc_sel;
                    if (bus.fetch_ctrl_mem_gnt_in) begin
                        state   <= WAIT;
                        mem_req <= 1'b0;
                        kill    <= redirect;
                    end else begin
                        mem_addr <= pc_sel;
                    end
                end
                WAIT: begin
                    if (bus.fetch_ctrl_mem_rvalid_in && !kill && !redirect) begin
                        state       <= HOLD;
                        instr       <= bus.fetch_ctrl_mem_rdata_in;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc_inc;
                    end else begin
                        pc <= pc_sel;
                        if (bus.fetch_ctrl_mem_rvalid_in) begin
                            state    <= REQ;
                            kill     <= 1'b0;
                            mem_req  <= 1'b1;
                            mem_addr <= pc_sel;
                        end else if (redirect) begin
                            kill <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (redirect || !bus.fetch_ctrl_stall_in) begin
                        state       <= REQ;
                        instr_valid <= 1'b0;
                        mem_req     <= 1'b1;
                        pc          <= pc_sel;
                        mem_addr    <= pc_sel;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of PC, address and instruction buses.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-003 Single clock, asynchronous active-high reset; all state SHALL be clocked on clock_in's rising edge.
REQ-004 clock_in  input  1  core clock.
REQ-005 reset_in  input  1  asynchronous reset, active high.
REQ-006 fetch_ctrl_mem_req_out  output  1  fetch request valid to instruction memory.
REQ-007 fetch_ctrl_mem_addr_out  output  DATA_WIDTH  fetch address (current PC).
REQ-008 fetch_ctrl_mem_gnt_in  input  1  memory accepts request this cycle.
REQ-009 fetch_ctrl_mem_rvalid_in  input  1  response data valid.
REQ-010 fetch_ctrl_mem_rdata_in  input  DATA_WIDTH  response instruction word.
REQ-011 fetch_ctrl_stall_in  input  1  decode not ready; hold delivered instruction.
REQ-012 fetch_ctrl_redirect_in  input  1  branch/jump/trap redirect strobe.
REQ-013 fetch_ctrl_redirect_addr_in  input  DATA_WIDTH  redirect target.
REQ-014 fetch_ctrl_instr_valid_out  output  1  instruction valid to decode.
REQ-015 fetch_ctrl_instr_out  output  DATA_WIDTH  instruction word.
REQ-016 fetch_ctrl_instr_pc_out  output  DATA_WIDTH  PC of delivered instruction.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD; IDLE->REQ unconditionally after one cycle.
REQ-018 In REQ, mem_req_out SHALL be 1 and mem_addr_out SHALL equal PC; gnt_in=1 -> WAIT, else stay REQ with req and addr stable.
REQ-019 In WAIT, rvalid_in=1 with kill flag clear SHALL register rdata into instr_out, PC into instr_pc_out, set instr_valid_out, set PC=PC+4, go HOLD.
REQ-020 PC increment SHALL wrap modulo 2^DATA_WIDTH (all-ones-minus-3 + 4 -> 0), no carry out.
REQ-021 In HOLD, instr_valid_out and instr/instr_pc SHALL stay stable while stall_in=1; stall_in=0 consumes the instruction, clears instr_valid_out next cycle, next state REQ.
REQ-022 Ideal memory (gnt tied 1, rvalid one cycle after gnt), no stall: one instruction per 3 cycles; first instr_valid_out 4 cycles after reset deassertion.
REQ-023 Redirect has priority over stall and over PC+4; it SHALL load PC with redirect_addr_in in the same edge.
REQ-024 Redirect in IDLE or REQ (incl. simultaneous gnt=0): PC replaced, state REQ, new address presented next cycle.
REQ-025 Redirect in REQ with gnt_in=1, or in WAIT: set kill flag, PC replaced; the in-flight response SHALL be discarded (no instr_valid_out), then REQ at new PC.
REQ-026 Redirect coincident with a non-killed rvalid in WAIT: response discarded, PC=redirect target.
REQ-027 Redirect in HOLD: instr_valid_out SHALL clear next cycle regardless of stall_in; state REQ.
REQ-028 rvalid_in outside WAIT SHALL be ignored; gnt_in outside REQ SHALL be ignored.

Reset
REQ-029 On reset_in=1, immediately: state IDLE, PC=RESET_VECTOR, kill flag 0, mem_req_out 0, mem_addr_out RESET_VECTOR, instr_valid_out 0, instr_out 0, instr_pc_out 0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request; late rvalid after reset SHALL be ignored.

Configuration
REQ-031 Macro FETCH_CTRL_MISALIGN_CHECK_EN defined: output fetch_ctrl_misalign_out (1 bit, reset 0) SHALL pulse one cycle when redirect_in=1 and redirect_addr_in[1:0]!=0; that redirect SHALL be ignored (PC, state unchanged).
REQ-032 Macro undefined: no misalign_out port; redirect target used as given, low bits unchecked.

Verification
REQ-033 Reset release, gnt=1, rvalid 1 cycle later, rdata=32'h00000013 -> instr_valid at cycle 4, instr_pc=0, next addr 4.
REQ-034 gnt held 0 for 5 cycles in REQ -> req=1, addr constant all 5 cycles; no valid.
REQ-035 Redirect to 32'h0000_0100 during WAIT -> pending response dropped, next mem_addr=32'h100, instr_pc=32'h100.
REQ-036 stall=1 for 3 cycles in HOLD -> instr/instr_pc stable; redirect during stall -> valid drops next cycle.
REQ-037 PC=32'hFFFF_FFFC fetch -> next mem_addr=0.
REQ-038 With FETCH_CTRL_MISALIGN_CHECK_EN, redirect to 32'h0000_0102 -> misalign_out pulse, fetch continues at PC+4.
